wb_port_ctrl: RTL and testbench
===============================

Name: wb_port_ctrl

Overview:
- Write-back port controller driving the single regfile write port (we/waddr/wdata).
- Merges in-order pipeline results with out-of-order results from the long-latency unit (divider/multi-cycle load).
- Long-unit results are buffered in a small FIFO and drained into idle write slots.
- Exposes pending-write query outputs for ID-stage interlock and a stall request against starvation.

Parameters:
- DEPTH, 2, long-unit result FIFO entries (power of 2, 2..8).
- STARVE_MAX, 4, consecutive blocked cycles before stall_req asserts (1..15).

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  reset; synchronous, active-high.
- pipe_we  in  1  pipeline write request; always accepted.
- pipe_waddr  in  5  pipeline destination register.
- pipe_wdata  in  32  pipeline result.
- lu_valid  in  1  long-unit result valid.
- lu_waddr  in  5  long-unit destination register.
- lu_wdata  in  32  long-unit result.
- lu_ready  out  1  FIFO can accept; transfer on lu_valid & lu_ready.
- we  out  1  regfile write enable, registered.
- waddr  out  5  regfile write address, registered.
- wdata  out  32  regfile write data, registered.
- qaddr1  in  5  ID read address 1.
- qaddr2  in  5  ID read address 2.
- pend1  out  1  qaddr1 has a buffered, unwritten long-unit result.
- pend2  out  1  same for qaddr2.
- stall_req  out  1  pipeline must hold off pipe_we, registered.

Behaviour:
- Reset (rst=1 at posedge): FIFO emptied, all valid bits cleared, count=0, starve counter=0. we=0, waddr=0, wdata=0, stall_req=0. While rst=1: lu_ready=0, pend1=pend2=0.
- Write-slot priority, evaluated each cycle t and registered at the next edge, so outputs are visible in cycle t+1 (latency 1):
  - 1) pipe_we=1 with pipe_waddr!=0: write the pipeline result.
  - 2) else count>0: pop the FIFO head. If the head is valid, write it. If the head was squashed, pop it with we=0.
  - 3) else we=0.
- we is never 1 with waddr=0.
- Accepting long-unit results:
  - lu_ready = (count<DEPTH) & !rst, based on registered count. A pop in the same cycle does not raise lu_ready.
  - Accepted with lu_waddr=0: discarded, no enqueue.
  - Accepted in the same cycle as pipe_we with equal nonzero address: discarded, since the pipeline write is younger.
  - Otherwise enqueued at the tail with valid=1.
  - Simultaneous enqueue and pop: count unchanged, pointers wrap modulo DEPTH.
- Squash: when pipe_we=1 and pipe_waddr!=0, every valid FIFO entry with matching waddr has its valid bit cleared at the edge. Its slot is freed only when it reaches the head.
- Pending outputs (combinational): pendN=1 iff qaddrN!=0 and some valid FIFO entry has waddr==qaddrN. Results already in the output register are not pending; the regfile's write-to-read bypass covers them.
- Starvation:
  - The starve counter increments on each cycle with count>0 and pipe_we=1, saturating at STARVE_MAX.
  - It clears on any cycle in which a pop occurs or count=0.
  - stall_req is registered; it is 1 from the edge after the counter reaches STARVE_MAX until the edge after the next pop.
  - The pipeline keeps priority even while stall_req=1.
- Reset mid-operation: buffered results are lost. An output write in flight at the reset edge is not emitted.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: when count=0, pipe_we=0 and lu_valid=1 with a nonzero address, the result is written directly at the next edge without enqueueing (latency 1). lu_ready is unchanged.
- Undefined: every accepted long-unit result is enqueued, then popped. Minimum latency is 2 cycles from acceptance to we=1.

Test Plan:
- Pipeline only: pipe_we=1, addr 3, data 0x11 at cycle 0 -> cycle 1: we=1, waddr=3, wdata=0x11. Cycle 2: we=0.
- Idle long-unit result: lu addr 5, data 0xAB accepted at cycle 0 with pipe_we=0.
  - Without WB_BYPASS_EN: pend (qaddr1=5) =1 in cycle 1; cycle 2 we=1, waddr=5.
  - With WB_BYPASS_EN: cycle 1 we=1, waddr=5; pend never 1.
- Fill and starvation (DEPTH=2, STARVE_MAX=4): two lu results accepted while pipe_we=1 continuously -> lu_ready=0 after 2 accepts. stall_req=1 after 4 blocked cycles. Drop pipe_we -> head written next cycle, stall_req=0 the edge after.
- Squash: lu addr 7 buffered; pipe_we addr 7, data 0x22 -> we=1, wdata=0x22; pend for 7 clears. The later pop of the squashed head gives a cycle with we=0; count returns to 0.
- Same-cycle conflict: lu_valid and pipe_we both to addr 9 -> only the pipeline write occurs, FIFO count stays 0. lu_waddr=0 accepted -> no write, no enqueue.
- Reset with 2 entries buffered and stall_req=1 -> next cycle we=0, stall_req=0, lu_ready=1 after rst deasserts, pend1=pend2=0.

Source files
------------

// File: rtl/wb_port_ctrl.sv
// Write-back port arbiter: pipeline writes win, buffered long-unit results fill idle slots; outputs registered (latency 1).
// lu_ready drops when the result FIFO is full; stall_req asks the pipeline to yield. Optional direct path: WB_BYPASS_EN.
module wb_port_ctrl #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    input  logic        lu_valid,
    input  logic [4:0]  lu_waddr,
    input  logic [31:0] lu_wdata,
    output logic        lu_ready,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    input  logic [4:0]  qaddr1,
    input  logic [4:0]  qaddr2,
    output logic        pend1,
    output logic        pend2,
    output logic        stall_req
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = 4;

    logic [4:0]       q_addr [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [DEPTH-1:0] q_vld;
    logic [DEPTH-1:0] q_vld_nxt;
    logic [DEPTH-1:0] squash;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [SW-1:0]    starve;

    logic pipe_hit;
    logic empty;
    logic lu_acc;
    logic pop;
    logic enq;
    logic bypass;

    assign empty    = (count == '0);
    assign pipe_hit = pipe_we && (pipe_waddr != 5'd0);
    assign lu_ready = (count < CW'(DEPTH)) && !rst;
    assign lu_acc   = lu_valid && lu_ready;
    assign pop      = !pipe_hit && !empty;

`ifdef WB_BYPASS_EN
    assign bypass = empty && !pipe_we && lu_valid && (lu_waddr != 5'd0);
`else
    assign bypass = 1'b0;
`endif

    // A same-cycle pipeline write to the same register is younger, so the long-unit result is dropped.
    assign enq = lu_acc && (lu_waddr != 5'd0)
               && !(pipe_hit && (lu_waddr == pipe_waddr))
               && !bypass;

    always_comb begin
        squash = '0;
        for (int i = 0; i < DEPTH; i++) begin
            squash[i] = pipe_hit && q_vld[i] && (q_addr[i] == pipe_waddr);
        end
    end

    // Squashed entries keep their slot until they reach the head.
    always_comb begin
        q_vld_nxt = q_vld & ~squash;
        if (pop) begin
            q_vld_nxt[head] = 1'b0;
        end
        if (enq) begin
            q_vld_nxt[tail] = 1'b1;
        end
    end

    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_vld[i] && (q_addr[i] == qaddr1)) begin
                pend1 = 1'b1;
            end
            if (q_vld[i] && (q_addr[i] == qaddr2)) begin
                pend2 = 1'b1;
            end
        end
        if (rst || (qaddr1 == 5'd0)) begin
            pend1 = 1'b0;
        end
        if (rst || (qaddr2 == 5'd0)) begin
            pend2 = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_addr[tail] <= lu_waddr;
            q_data[tail] <= lu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            q_vld     <= '0;
            starve    <= '0;
            stall_req <= 1'b0;
            we        <= 1'b0;
            waddr     <= 5'd0;
            wdata     <= 32'd0;
        end else begin
            q_vld <= q_vld_nxt;
            if (pop) begin
                head <= head + PW'(1);
            end
            if (enq) begin
                tail <= tail + PW'(1);
            end
            case ({enq, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (pop || empty) begin
                starve <= '0;
            end else if (pipe_we && (starve < SW'(STARVE_MAX))) begin
                starve <= starve + SW'(1);
            end
            stall_req <= (starve == SW'(STARVE_MAX));

            if (pipe_hit) begin
                we    <= 1'b1;
                waddr <= pipe_waddr;
                wdata <= pipe_wdata;
            end else if (pop) begin
                we <= q_vld[head];
                if (q_vld[head]) begin
                    waddr <= q_addr[head];
                    wdata <= q_data[head];
                end
            end else if (bypass) begin
                we    <= 1'b1;
                waddr <= lu_waddr;
                wdata <= lu_wdata;
            end else begin
                we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_ctrl.sv
// Directed + random bench for wb_port_ctrl against a queue-based reference model.
module tb_wb_port_ctrl;

    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_we = 1'b0;
    logic [4:0]  pipe_waddr = '0;
    logic [31:0] pipe_wdata = '0;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_waddr = '0;
    logic [31:0] lu_wdata = '0;
    logic        lu_ready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  qaddr1 = '0;
    logic [4:0]  qaddr2 = '0;
    logic        pend1;
    logic        pend2;
    logic        stall_req;

    wb_port_ctrl #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .lu_valid(lu_valid), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata), .lu_ready(lu_ready),
        .we(we), .waddr(waddr), .wdata(wdata),
        .qaddr1(qaddr1), .qaddr2(qaddr2), .pend1(pend1), .pend2(pend2),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic        v;
    } ent_t;

    ent_t        q[$];
    int          scnt = 0;
    logic        e_we = 1'b0;
    logic [4:0]  e_waddr = '0;
    logic [31:0] e_wdata = '0;
    logic        e_stall = 1'b0;
    logic        chk_dat = 1'b0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic m_pend(logic [4:0] a);
        if (rst || a == 5'd0) return 1'b0;
        foreach (q[i]) if (q[i].v && q[i].a == a) return 1'b1;
        return 1'b0;
    endfunction

    // Advance the reference by one clock using the inputs currently applied.
    task automatic model_step();
        logic ph, acc, byp, popped;
        int   n0;
        ent_t h;
        if (rst) begin
            q.delete();
            scnt    = 0;
            e_we    = 1'b0;
            e_waddr = '0;
            e_wdata = '0;
            e_stall = 1'b0;
            chk_dat = 1'b1;
            return;
        end
        chk_dat = 1'b0;
        n0      = q.size();
        ph      = pipe_we && (pipe_waddr != 5'd0);
        acc     = lu_valid && (n0 < DEPTH);
        byp     = 1'b0;
`ifdef WB_BYPASS_EN
        byp = (n0 == 0) && !pipe_we && lu_valid && (lu_waddr != 5'd0);
`endif
        e_stall = (scnt == SMAX);
        popped  = 1'b0;
        if (ph) begin
            e_we = 1'b1; e_waddr = pipe_waddr; e_wdata = pipe_wdata;
            foreach (q[i]) if (q[i].a == pipe_waddr) q[i].v = 1'b0;
        end else if (n0 > 0) begin
            h = q.pop_front();
            popped = 1'b1;
            e_we = h.v;
            if (h.v) begin e_waddr = h.a; e_wdata = h.d; end
        end else if (byp) begin
            e_we = 1'b1; e_waddr = lu_waddr; e_wdata = lu_wdata;
        end else begin
            e_we = 1'b0;
        end
        if (popped || n0 == 0) scnt = 0;
        else if (pipe_we && scnt < SMAX) scnt++;
        if (acc && lu_waddr != 5'd0 && !(ph && lu_waddr == pipe_waddr) && !byp)
            q.push_back('{lu_waddr, lu_wdata, 1'b1});
    endtask

    task automatic step(logic r, logic pwe, logic [4:0] pa, logic [31:0] pd,
                        logic lv, logic [4:0] la, logic [31:0] ld,
                        logic [4:0] q1, logic [4:0] q2);
        rst = r; pipe_we = pwe; pipe_waddr = pa; pipe_wdata = pd;
        lu_valid = lv; lu_waddr = la; lu_wdata = ld; qaddr1 = q1; qaddr2 = q2;
        #1;
        chk("lu_ready", lu_ready, (!r && q.size() < DEPTH));
        chk("pend1", pend1, m_pend(q1));
        chk("pend2", pend2, m_pend(q2));
        model_step();
        @(posedge clk);
        #1;
        chk("we", we, e_we);
        chk("stall_req", stall_req, e_stall);
        if (e_we || chk_dat) begin
            chk("waddr", waddr, e_waddr);
            chk("wdata", wdata, e_wdata);
        end
    endtask

    task automatic idle(logic [4:0] q1);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, q1, 5'd0);
    endtask

    initial begin
        // Reset state
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        step(1'b1, 1'b1, 5'd3, 32'h55, 1'b1, 5'd4, 32'h66, 5'd4, 5'd3);
        // Pipeline only
        step(1'b0, 1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
        idle(5'd3);
        // Idle long-unit result
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hAB, 5'd5, 5'd0);
        idle(5'd5);
        idle(5'd5);
        // Fill and starvation
        step(1'b0, 1'b1, 5'd1, 32'h100, 1'b1, 5'd2, 32'h200, 5'd2, 5'd4);
        step(1'b0, 1'b1, 5'd1, 32'h101, 1'b1, 5'd4, 32'h400, 5'd2, 5'd4);
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, 5'd1, 32'h102 + i, 1'b1, 5'd6, 32'h600, 5'd2, 5'd6);
        for (int i = 0; i < 4; i++) idle(5'd4);
        // Squash of a buffered result
        step(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'h77, 5'd7, 5'd0);
        step(1'b0, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
        idle(5'd7);
        idle(5'd7);
        idle(5'd7);
        // Same-cycle conflict and zero-address result
        step(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 32'h98, 5'd9, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h12, 5'd0, 5'd9);
        idle(5'd9);
        // Reset with a full FIFO and stall_req raised
        step(1'b0, 1'b1, 5'd1, 32'h3, 1'b1, 5'd10, 32'hA0, 5'd10, 5'd11);
        step(1'b0, 1'b1, 5'd1, 32'h4, 1'b1, 5'd11, 32'hB0, 5'd10, 5'd11);
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, 5'd2, 32'h5 + i, 1'b0, 5'd0, 32'd0, 5'd10, 5'd11);
        step(1'b1, 1'b1, 5'd2, 32'h9, 1'b0, 5'd0, 32'd0, 5'd10, 5'd11);
        idle(5'd10);
        idle(5'd11);
        // Random traffic over a small address range to provoke hazards
        for (int k = 0; k < 800; k++) begin
            step($urandom_range(0, 79) == 0,
                 $urandom_range(0, 2) != 0,
                 5'($urandom_range(0, 3)),
                 $urandom,
                 $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 3)),
                 $urandom,
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
